// File: rtl/align_pkg.sv
// rtl/align_pkg.sv - width helpers shared by the align_* width converters
package align_pkg;

    function automatic int align_reg_num(input int iw, input int ow);
        return (ow > 0) ? iw / ow : 0;
    endfunction

    // Wide enough to hold the value n itself, not just 0..n-1.
    function automatic int align_cnt_bit(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/align_word_fifo2.sv
// rtl/align_word_fifo2.sv - two-entry word FIFO, head visible on rdata
module align_word_fifo2
    import align_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         push_ok, pop_ok;

    always_comb begin
        push_ok  = push && (count_q != 2'd2);
        pop_ok   = pop && (count_q != 2'd0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Payload storage carries no reset; only the pointers define what is live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        rdata = mem_q[rd_ptr_q];
        full  = (count_q == 2'd2);
        empty = (count_q == 2'd0);
        count = count_q;
    end

endmodule

// File: rtl/align_p2s_stream.sv
// rtl/align_p2s_stream.sv - backpressured wide-word to narrow-segment unpacker
module align_p2s_stream
    import align_pkg::*;
#(
    parameter  int IDATA_BIT = 256,
    parameter  int ODATA_BIT = 64,
    localparam int REG_NUM   = align_reg_num(IDATA_BIT, ODATA_BIT),
    localparam int CNT_BIT   = align_cnt_bit(REG_NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDATA_BIT-1:0] idata,
    input  logic [CNT_BIT-1:0]   idata_cnt,
    input  logic                 idata_last,
    input  logic                 idata_valid,
    output logic                 idata_ready,
    output logic [ODATA_BIT-1:0] odata,
    output logic                 odata_last,
    output logic                 odata_valid,
    input  logic                 odata_ready,
    output logic                 busy
);

    localparam int                 FW      = IDATA_BIT + CNT_BIT + 1;
    localparam logic [CNT_BIT-1:0] CNT_MAX = CNT_BIT'(REG_NUM);

    generate
        if ((IDATA_BIT % ODATA_BIT) != 0 || REG_NUM < 1) begin : g_bad_params
            $error("align_p2s_stream: IDATA_BIT must be a nonzero multiple of ODATA_BIT");
        end
    endgenerate

    logic                 run_q, run_d;
    logic [CNT_BIT-1:0]   seg_idx_q, seg_idx_d;
    logic [CNT_BIT-1:0]   cnt_eff;
    logic [FW-1:0]        fifo_wdata, fifo_rdata;
    logic                 fifo_full, fifo_empty;
    logic [1:0]           fifo_count;
    logic [IDATA_BIT-1:0] head_data;
    logic [CNT_BIT-1:0]   head_cnt;
    logic                 head_last;
    logic                 push, pop, fire, at_end;

    align_word_fifo2 #(
        .W(FW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Zero or an oversized count means a full word; stored counts are always 1..REG_NUM.
    always_comb begin
        cnt_eff    = ((idata_cnt == '0) || (idata_cnt > CNT_MAX)) ? CNT_MAX : idata_cnt;
        fifo_wdata = {idata_last, cnt_eff, idata};
        {head_last, head_cnt, head_data} = fifo_rdata;
    end

    always_comb begin
        run_d     = 1'b1;
        seg_idx_d = seg_idx_q;
        if (fire) begin
            seg_idx_d = at_end ? '0 : seg_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q     <= 1'b0;
            seg_idx_q <= '0;
        end else begin
            run_q     <= run_d;
            seg_idx_q <= seg_idx_d;
        end
    end

    // idata_ready comes from registered state only, so odata_ready never reaches it.
    always_comb begin
        idata_ready = run_q && !fifo_full;
        odata_valid = !fifo_empty;
        busy        = (fifo_count != 2'd0);
        push        = idata_valid && idata_ready;
        fire        = odata_valid && odata_ready;
        at_end      = (seg_idx_q == head_cnt - 1'b1);
        pop         = fire && at_end;
        odata_last  = odata_valid && head_last && at_end;
        odata       = '0;
        for (int k = 0; k < REG_NUM; k++) begin
            if (odata_valid && (seg_idx_q == CNT_BIT'(k))) begin
                odata = head_data[k*ODATA_BIT +: ODATA_BIT];
            end
        end
    end

endmodule

// File: tb/tb_align_p2s_stream.sv
// tb/tb_align_p2s_stream.sv - randomized scoreboard bench for align_p2s_stream
module tb_align_p2s_stream;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } seg_t;

    logic         clk;
    logic         rst;
    logic [255:0] idata;
    logic [2:0]   idata_cnt;
    logic         idata_last;
    logic         idata_valid;
    logic         idata_ready;
    logic [63:0]  odata;
    logic         odata_last;
    logic         odata_valid;
    logic         odata_ready;
    logic         busy;

    logic [63:0]  idata1;
    logic [0:0]   idata1_cnt;
    logic         idata1_last;
    logic         idata1_valid;
    logic         idata1_ready;
    logic [63:0]  odata1;
    logic         odata1_last;
    logic         odata1_valid;
    logic         odata1_ready;
    logic         busy1;

    int           errors = 0;
    int           checks = 0;
    int           ready_mode = 0;
    logic         mon_en = 1'b0;
    logic         mon1_en = 1'b0;
    logic         stall_prev = 1'b0;
    logic [64:0]  stall_val;
    int           saw_full = 0;
    int           acc1 = 0;
    seg_t         seg_q[$];
    int           rem_q[$];
    seg_t         q1[$];

    align_p2s_stream #(.IDATA_BIT(256), .ODATA_BIT(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .idata       (idata),
        .idata_cnt   (idata_cnt),
        .idata_last  (idata_last),
        .idata_valid (idata_valid),
        .idata_ready (idata_ready),
        .odata       (odata),
        .odata_last  (odata_last),
        .odata_valid (odata_valid),
        .odata_ready (odata_ready),
        .busy        (busy)
    );

    align_p2s_stream #(.IDATA_BIT(64), .ODATA_BIT(64)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .idata       (idata1),
        .idata_cnt   (idata1_cnt),
        .idata_last  (idata1_last),
        .idata_valid (idata1_valid),
        .idata_ready (idata1_ready),
        .odata       (odata1),
        .odata_last  (odata1_last),
        .odata_valid (odata1_valid),
        .odata_ready (odata1_ready),
        .busy        (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand_word();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    always @(posedge clk) begin
        #1;
        if (ready_mode == 1) odata_ready = ($urandom_range(0, 3) != 0);
        else if (ready_mode == 2) odata_ready = 1'b0;
        else odata_ready = 1'b1;
    end

    // Scoreboard for the 256->64 instance: words become segment lists at acceptance.
    always @(negedge clk) begin
        seg_t s;
        int   eff;
        if (!rst && mon_en) begin
            chk("valid", 256'(odata_valid), 256'(rem_q.size() != 0));
            chk("busy", 256'(busy), 256'(rem_q.size() != 0));
            chk("iready", 256'(idata_ready), 256'(rem_q.size() < 2));
            if (rem_q.size() == 2) saw_full++;
            if (!odata_valid) chk("odata_idle", 256'({odata_last, odata}), 256'(0));
            if (stall_prev) chk("stable", 256'({odata_last, odata}), 256'(stall_val));
            stall_prev = odata_valid && !odata_ready;
            stall_val  = {odata_last, odata};
            if (odata_valid && odata_ready) begin
                if (seg_q.size() == 0) begin
                    chk("scoreboard_nonempty", 256'(seg_q.size()), 256'(1));
                end else begin
                    s = seg_q.pop_front();
                    chk("odata", 256'(odata), 256'(s.data));
                    chk("olast", 256'(odata_last), 256'(s.last));
                    rem_q[0] = rem_q[0] - 1;
                    if (rem_q[0] == 0) void'(rem_q.pop_front());
                end
            end
            if (idata_valid && idata_ready) begin
                eff = (idata_cnt == 3'd0 || idata_cnt > 3'd4) ? 4 : int'(idata_cnt);
                for (int k = 0; k < eff; k++) begin
                    s.data = idata[k*64 +: 64];
                    s.last = idata_last && (k == eff - 1);
                    seg_q.push_back(s);
                end
                rem_q.push_back(eff);
            end
        end
    end

    always @(negedge clk) begin
        seg_t s;
        if (!rst && mon1_en) begin
            chk("w1_valid", 256'(odata1_valid), 256'(q1.size() != 0));
            chk("w1_iready", 256'(idata1_ready), 256'(q1.size() < 2));
            chk("w1_busy", 256'(busy1), 256'(q1.size() != 0));
            if (odata1_valid && odata1_ready) begin
                if (q1.size() == 0) begin
                    chk("w1_nonempty", 256'(q1.size()), 256'(1));
                end else begin
                    s = q1.pop_front();
                    chk("w1_odata", 256'(odata1), 256'(s.data));
                    chk("w1_olast", 256'(odata1_last), 256'(s.last));
                end
            end
            if (idata1_valid && idata1_ready) begin
                s.data = idata1;
                s.last = idata1_last;
                q1.push_back(s);
                acc1++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [255:0] d, input logic [2:0] c, input logic l);
        int   n;
        logic acc;
        n           = 0;
        acc         = 1'b0;
        idata       = d;
        idata_cnt   = c;
        idata_last  = l;
        idata_valid = 1'b1;
        while (!acc && n < 500) begin
            @(negedge clk);
            acc = idata_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("send_timeout", 256'(acc), 256'(1));
        idata_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (seg_q.size() != 0 && n < 5000) begin
            tick(1);
            n++;
        end
        chk("drain", 256'(seg_q.size()), 256'(0));
        tick(2);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst          = 1'b1;
        idata        = '0;
        idata_cnt    = '0;
        idata_last   = 1'b0;
        idata_valid  = 1'b0;
        idata1       = '0;
        idata1_cnt   = '0;
        idata1_last  = 1'b0;
        idata1_valid = 1'b0;
        odata1_ready = 1'b1;
        #3;
        chk("rst_iready", 256'(idata_ready), 256'(0));
        chk("rst_ovalid", 256'(odata_valid), 256'(0));
        chk("rst_odata", 256'({odata_last, odata}), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1);
        chk("iready_after_rst", 256'(idata_ready), 256'(1));
        mon_en = 1'b1;

        send_word({64'h4444444444444444, 64'h3333333333333333,
                   64'h2222222222222222, 64'h1111111111111111}, 3'd0, 1'b0);
        wait_drain();

        for (int i = 0; i < 3; i++) send_word(rand_word(), 3'd4, 1'(i == 2));
        wait_drain();
        chk("saw_full", 256'(saw_full > 0), 256'(1));

        send_word(rand_word(), 3'd2, 1'b1);
        send_word(rand_word(), 3'd7, 1'b1);
        send_word(rand_word(), 3'd1, 1'b0);
        wait_drain();

        ready_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            send_word(rand_word(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            tick($urandom_range(0, 2));
        end
        wait_drain();
        ready_mode = 0;
        tick(1);

        send_word(rand_word(), 3'd4, 1'b1);
        n = 0;
        while (seg_q.size() > 2 && n < 50) begin
            tick(1);
            n++;
        end
        chk("mid_word_reached", 256'(seg_q.size()), 256'(2));
        #1;
        rst = 1'b1;
        #1;
        chk("arst_ovalid", 256'(odata_valid), 256'(0));
        chk("arst_odata", 256'({odata_last, odata}), 256'(0));
        chk("arst_iready", 256'(idata_ready), 256'(0));
        chk("arst_busy", 256'(busy), 256'(0));
        mon_en     = 1'b0;
        stall_prev = 1'b0;
        seg_q.delete();
        rem_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(2);
        chk("post_rst_idle", 256'(odata_valid), 256'(0));
        mon_en = 1'b1;
        send_word({64'hdddd, 64'hcccc, 64'hbbbb, 64'haaaa}, 3'd0, 1'b1);
        wait_drain();

        mon1_en = 1'b1;
        for (int i = 0; i < 50; i++) begin
            idata1       = {$urandom, $urandom};
            idata1_cnt   = 1'($urandom_range(0, 1));
            idata1_last  = 1'($urandom_range(0, 1));
            idata1_valid = 1'b1;
            tick(1);
        end
        idata1_valid = 1'b0;
        tick(3);
        chk("w1_accepts", 256'(acc1), 256'(50));
        chk("w1_drain", 256'(q1.size()), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
